// File: rtl/test_pulse_checker_pkg.sv
// Shared types, default widths and the saturating-increment helper for the test-pulse checker.
package tpcheck_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int LATW_D = 8;
    localparam int CNTW_D = 16;

    // Counters of any width up to 32 bits are passed zero-extended; the result sticks at all-ones of that width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] top;
        top = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= top) ? top : (value + 32'd1);
    endfunction

endpackage

// File: rtl/test_pulse_checker_if.sv
// Stimulus and result bundle between the pulse generator/board controller and the checker.
interface tpcheck_if
    import tpcheck_pkg::*;
#(
    parameter int LATW = LATW_D,
    parameter int CNTW = CNTW_D
);
    logic            enable;
    logic            clear;
    logic            testpulse;
    logic            hitin;
    logic            lat_valid;
    logic [LATW-1:0] latency;
    logic            miss;
    logic [CNTW-1:0] hit_count;
    logic [CNTW-1:0] miss_count;
    logic [CNTW-1:0] stray_count;
    logic [LATW-1:0] lat_min;
    logic [LATW-1:0] lat_max;

    modport master (
        output enable, clear, testpulse, hitin,
        input  lat_valid, latency, miss, hit_count, miss_count, stray_count, lat_min, lat_max
    );

    modport slave (
        input  enable, clear, testpulse, hitin,
        output lat_valid, latency, miss, hit_count, miss_count, stray_count, lat_min, lat_max
    );
endinterface

// File: rtl/test_pulse_checker_rise_detect.sv
// Registers the returned hit level and flags its rising edge one cycle after it is sampled.
module rise_detect (
    input  logic clk4x,
    input  logic reset_n,
    input  logic hitin,
    output logic hit_edge
);
    logic hitin_r;
    logic hitin_q_r;

    // Capture stage plus one-cycle history for edge detection.
    always_ff @(posedge clk4x) begin
        if (!reset_n) begin
            hitin_r   <= 1'b0;
            hitin_q_r <= 1'b0;
        end else begin
            hitin_r   <= hitin;
            hitin_q_r <= hitin_r;
        end
    end

    assign hit_edge = hitin_r & ~hitin_q_r;
endmodule

// File: rtl/test_pulse_checker.sv
// Measures test-pulse to hit latency in clk4x cycles and keeps pass/miss/stray statistics.
// Optional min/max latency tracking is built when TPCHECK_MINMAX_EN is defined.
module test_pulse_checker
    import tpcheck_pkg::*;
#(
    parameter int MAXLAT = 32,
    parameter int LATW   = LATW_D,
    parameter int CNTW   = CNTW_D
) (
    input logic     clk4x,
    input logic     reset_n,
    tpcheck_if.slave bus
);
    localparam logic [LATW-1:0] MAXLAT_L = LATW'(MAXLAT);

    state_t          state_r, state_s;
    logic [LATW-1:0] timer_r, timer_s;
    logic [LATW-1:0] k_s;
    logic            hit_edge_s;
    logic            lv_s, miss_s, stray_s;
    logic            lat_valid_r, miss_r;
    logic [LATW-1:0] latency_r;
    logic [CNTW-1:0] hit_cnt_r, miss_cnt_r, stray_cnt_r;

    rise_detect u_rise_detect (
        .clk4x    (clk4x),
        .reset_n  (reset_n),
        .hitin    (bus.hitin),
        .hit_edge (hit_edge_s)
    );

    // Timer holds cycles elapsed minus one, so k is the latency of an edge seen this cycle.
    assign k_s = timer_r + LATW'(1'b1);

    // Next-state, timer and strobe decode for the measurement window.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        lv_s    = 1'b0;
        miss_s  = 1'b0;
        stray_s = 1'b0;
        if (!bus.enable) begin
            state_s = IDLE;
            timer_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    stray_s = hit_edge_s;
                    if (bus.testpulse) begin
                        state_s = WAIT;
                        timer_s = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                WAIT: begin
                    // A hit edge always closes the old window, even when a new pulse arrives with it.
                    lv_s   = hit_edge_s;
                    miss_s = ~hit_edge_s & (bus.testpulse | (k_s == MAXLAT_L));
                    if (bus.testpulse) begin
                        state_s = WAIT;
                        timer_s = '0;
                    end else if (hit_edge_s || (k_s == MAXLAT_L)) begin
                        state_s = IDLE;
                        timer_s = '0;
                    end else begin
                        timer_s = k_s;
                    end
                end
                default: begin
                    state_s = IDLE;
                    timer_s = '0;
                end
            endcase
        end
    end

    // FSM, timer and result strobes.
    always_ff @(posedge clk4x) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            timer_r     <= '0;
            lat_valid_r <= 1'b0;
            miss_r      <= 1'b0;
            latency_r   <= '0;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            lat_valid_r <= lv_s;
            miss_r      <= miss_s;
            if (lv_s) begin
                latency_r <= k_s;
            end
        end
    end

    // Saturating statistics; clear overrides any increment on the same cycle.
    always_ff @(posedge clk4x) begin
        if (!reset_n || bus.clear) begin
            hit_cnt_r   <= '0;
            miss_cnt_r  <= '0;
            stray_cnt_r <= '0;
        end else begin
            if (lv_s) begin
                hit_cnt_r <= CNTW'(sat_inc(32'(hit_cnt_r), CNTW));
            end
            if (miss_s) begin
                miss_cnt_r <= CNTW'(sat_inc(32'(miss_cnt_r), CNTW));
            end
            if (stray_s) begin
                stray_cnt_r <= CNTW'(sat_inc(32'(stray_cnt_r), CNTW));
            end
        end
    end

`ifdef TPCHECK_MINMAX_EN
    logic [LATW-1:0] lat_min_r, lat_max_r;

    // Latency extremes since reset or clear.
    always_ff @(posedge clk4x) begin
        if (!reset_n || bus.clear) begin
            lat_min_r <= '1;
            lat_max_r <= '0;
        end else if (lv_s) begin
            if (k_s < lat_min_r) begin
                lat_min_r <= k_s;
            end
            if (k_s > lat_max_r) begin
                lat_max_r <= k_s;
            end
        end
    end

    assign bus.lat_min = lat_min_r;
    assign bus.lat_max = lat_max_r;
`else
    assign bus.lat_min = '1;
    assign bus.lat_max = '0;
`endif

    assign bus.lat_valid   = lat_valid_r;
    assign bus.latency     = latency_r;
    assign bus.miss        = miss_r;
    assign bus.hit_count   = hit_cnt_r;
    assign bus.miss_count  = miss_cnt_r;
    assign bus.stray_count = stray_cnt_r;
endmodule

// File: tb/tb_test_pulse_checker.sv
// Self-checking bench: directed scenarios plus random traffic against a timestamp-based reference model.
module tb_test_pulse_checker;
    localparam int MAXLAT = 32;
    localparam int LATW   = 8;
    localparam int CNTW   = 4;
    localparam int CMAX   = (1 << CNTW) - 1;
    localparam int LMAX   = (1 << LATW) - 1;

    logic clk4x = 1'b0;
    logic reset_n;

    tpcheck_if #(.LATW(LATW), .CNTW(CNTW)) bus ();

    test_pulse_checker #(.MAXLAT(MAXLAT), .LATW(LATW), .CNTW(CNTW)) dut (
        .clk4x   (clk4x),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk4x = ~clk4x;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a pending pulse is remembered by its cycle number.
    int cyc = 0;
    int pend = -1;
    bit h1 = 1'b0;
    bit h2 = 1'b0;
    bit m_lv = 1'b0;
    bit m_ms = 1'b0;
    int m_lat = 0;
    int m_hit = 0;
    int m_miss = 0;
    int m_stray = 0;
    int m_min = LMAX;
    int m_max = 0;
    bit seen_lv = 1'b0;
    bit seen_miss = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit tp, input bit hi, input bit en, input bit cl, input bit rst);
        bit d;
        int k;
        bit inc_h, inc_m, inc_s;
        cyc++;
        if (rst) begin
            pend = -1; h1 = 1'b0; h2 = 1'b0;
            m_lv = 1'b0; m_ms = 1'b0; m_lat = 0;
            m_hit = 0; m_miss = 0; m_stray = 0;
            m_min = LMAX; m_max = 0;
        end else begin
            d = h1 & ~h2;
            h2 = h1;
            h1 = hi;
            m_lv = 1'b0; m_ms = 1'b0;
            inc_h = 1'b0; inc_m = 1'b0; inc_s = 1'b0;
            if (en) begin
                if (pend >= 0) begin
                    k = cyc - pend;
                    if (d) begin
                        m_lv = 1'b1; m_lat = k; inc_h = 1'b1; pend = -1;
                    end else if (tp || k == MAXLAT) begin
                        m_ms = 1'b1; inc_m = 1'b1; pend = -1;
                    end
                end else if (d) begin
                    inc_s = 1'b1;
                end
                if (tp) pend = cyc;
            end else begin
                pend = -1;
            end
            if (cl) begin
                m_hit = 0; m_miss = 0; m_stray = 0; m_min = LMAX; m_max = 0;
            end else begin
                if (inc_h && m_hit < CMAX) m_hit++;
                if (inc_m && m_miss < CMAX) m_miss++;
                if (inc_s && m_stray < CMAX) m_stray++;
`ifdef TPCHECK_MINMAX_EN
                if (m_lv && m_lat < m_min) m_min = m_lat;
                if (m_lv && m_lat > m_max) m_max = m_lat;
`endif
            end
        end
    endtask

    task automatic compare_all();
        check_eq("lat_valid",   32'(bus.lat_valid),   32'(m_lv));
        check_eq("miss",        32'(bus.miss),        32'(m_ms));
        check_eq("latency",     32'(bus.latency),     32'(m_lat));
        check_eq("hit_count",   32'(bus.hit_count),   32'(m_hit));
        check_eq("miss_count",  32'(bus.miss_count),  32'(m_miss));
        check_eq("stray_count", 32'(bus.stray_count), 32'(m_stray));
        check_eq("lat_min",     32'(bus.lat_min),     32'(m_min));
        check_eq("lat_max",     32'(bus.lat_max),     32'(m_max));
    endtask

    task automatic step(input bit tp, input bit hi, input bit en, input bit cl, input bit rst);
        bus.testpulse = tp;
        bus.hitin     = hi;
        bus.enable    = en;
        bus.clear     = cl;
        reset_n       = ~rst;
        @(posedge clk4x);
        model_edge(tp, hi, en, cl, rst);
        #1;
        compare_all();
        seen_lv   = seen_lv | bus.lat_valid;
        seen_miss = seen_miss | bus.miss;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        seen_lv = 1'b0;
        seen_miss = 1'b0;
    endtask

    // Pulse, then a hitin rise timed so the edge is detected lat cycles after the pulse (lat >= 2).
    task automatic measure(input int lat);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < lat - 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bit hcur;
        int flip_div;
        bus.testpulse = 1'b0; bus.hitin = 1'b0; bus.enable = 1'b0; bus.clear = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_lat_valid", 32'(bus.lat_valid), 32'd0);
        check_eq("rst_latency",   32'(bus.latency),   32'd0);
        check_eq("rst_hit_count", 32'(bus.hit_count), 32'd0);
        check_eq("rst_lat_min",   32'(bus.lat_min),   32'd255);
        check_eq("rst_lat_max",   32'(bus.lat_max),   32'd0);
        idle(2);

        // Latency 5 measurement.
        measure(5);
        check_eq("t1_lat_valid", 32'(bus.lat_valid), 32'd1);
        check_eq("t1_latency",   32'(bus.latency),   32'd5);
        check_eq("t1_hit_count", 32'(bus.hit_count), 32'd1);
        idle(3);

        // Window expiry.
        do_clear();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(31);
        check_eq("t2_miss_early", 32'(bus.miss), 32'd0);
        idle(1);
        check_eq("t2_miss",       32'(bus.miss),       32'd1);
        check_eq("t2_miss_count", 32'(bus.miss_count), 32'd1);
        check_eq("t2_no_lat",     32'(seen_lv),        32'd0);
        idle(2);

        // Re-pulse while waiting: old pulse misses, new one measures 5.
        do_clear();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(9);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_miss", 32'(bus.miss), 32'd1);
        idle(3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t3_latency",    32'(bus.latency),    32'd5);
        check_eq("t3_miss_count", 32'(bus.miss_count), 32'd1);
        check_eq("t3_hit_count",  32'(bus.hit_count),  32'd1);
        idle(3);

        // Stray edges: one in IDLE, one on the pulse cycle itself.
        do_clear();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t4_stray_count", 32'(bus.stray_count), 32'd2);
        idle(34);
        check_eq("t4_no_lat", 32'(seen_lv), 32'd0);

        // Disable mid-window, then an edge while disabled.
        do_clear();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 36; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_eq("t5_miss_count",  32'(bus.miss_count),  32'd0);
        check_eq("t5_hit_count",   32'(bus.hit_count),   32'd0);
        check_eq("t5_stray_count", 32'(bus.stray_count), 32'd0);
        check_eq("t5_no_strobes",  32'(seen_lv | seen_miss), 32'd0);

        // Saturation with back-to-back pulses, then clear.
        do_clear();
        for (int i = 0; i < 21; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t6_miss_sat", 32'(bus.miss_count), 32'd15);
        do_clear();
        check_eq("t6_miss_clear", 32'(bus.miss_count), 32'd0);
        idle(34);

        // Latency extremes.
        do_clear();
        measure(7); idle(2);
        measure(3); idle(2);
        measure(9); idle(2);
`ifdef TPCHECK_MINMAX_EN
        check_eq("t7_lat_min", 32'(bus.lat_min), 32'd3);
        check_eq("t7_lat_max", 32'(bus.lat_max), 32'd9);
`else
        check_eq("t7_lat_min", 32'(bus.lat_min), 32'd255);
        check_eq("t7_lat_max", 32'(bus.lat_max), 32'd0);
`endif
        check_eq("t7_hit_count", 32'(bus.hit_count), 32'd3);

        // Random traffic alternating dense and sparse hit activity.
        hcur = 1'b0;
        flip_div = 4;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 256) == 0) flip_div = ($urandom_range(1) == 1) ? 4 : 48;
            if ($urandom_range(flip_div - 1) == 0) hcur = ~hcur;
            step(($urandom_range(15) == 0), hcur, ($urandom_range(63) != 0),
                 ($urandom_range(299) == 0), ($urandom_range(999) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
